// File: rtl/tof_pll_serial_monitor_pkg.sv
// Shared definitions for the PLL serial-programming monitor: word geometry,
// control-bit codes that select the shadow register, and reference words.
package tof_pll_serial_monitor_pkg;

  localparam int PLL_WORD_W = 24;
  localparam int BITCNT_W   = 5;

  // C2:C1 = word[1:0] selects which PLL register a word targets
  typedef enum logic [1:0] {
    C_CTRL = 2'b00,
    C_RCNT = 2'b01,
    C_NCNT = 2'b10,
    C_TEST = 2'b11
  } c_bits_e;

  // Typical power-up programming sequence (R, control, N)
  localparam logic [PLL_WORD_W-1:0] INIT_R_WORD    = 24'h34002D;
  localparam logic [PLL_WORD_W-1:0] INIT_CTRL_WORD = 24'h0481A4;
  localparam logic [PLL_WORD_W-1:0] INIT_N_WORD    = 24'h002C0A;

  // Bit counter increment that sticks at its maximum so overlong frames stay visible
  function automatic logic [BITCNT_W-1:0] bitcnt_inc(input logic [BITCNT_W-1:0] cnt);
    logic [BITCNT_W-1:0] res;
    if (cnt != {BITCNT_W{1'b1}}) begin
      res = cnt + BITCNT_W'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/tof_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level, plus registered
// one-cycle rise/fall strobes derived from the synchronized level.
module tof_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Advance the synchronizer chain and compare synced level with its previous value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // Synchronizer, edge-detect and strobe registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/tof_pll_serial_monitor.sv
// Receive-side snoop of the 3-wire PLL programming bus. Rebuilds each latched
// word, keeps shadows of the control/R/N registers, flags malformed frames and
// synchronizes the PLL lock indication.
module tof_pll_serial_monitor
  import tof_pll_serial_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_W      = PLL_WORD_W,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pll_sclk_i,
  input  logic                pll_sdin_i,
  input  logic                pll_load_i,
  input  logic                pll_lock_i,
  output logic [WORD_W-1:0]   word_o,
  output logic                word_valid_o,
  output logic [WORD_W-1:0]   ctrl_reg_o,
  output logic [WORD_W-1:0]   r_reg_o,
  output logic [WORD_W-1:0]   n_reg_o,
  output logic [2:0]          loaded_o,
  output logic                frame_err_o,
  output logic [ERRCNT_W-1:0] err_count_o,
  output logic                lock_o,
  output logic                lock_lost_o
);

  localparam logic [BITCNT_W-1:0] CNT_FULL = BITCNT_W'(WORD_W);
  localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};

  // Synchronized pin views
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic load_level_s, load_rise_s, load_fall_s;
  logic lock_level_s, lock_rise_s, lock_fall_s;
  logic unused_edges_s;

  tof_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(pll_sclk_i),
    .level_o(sclk_level_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  tof_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(pll_load_i),
    .level_o(load_level_s), .rise_o(load_rise_s), .fall_o(load_fall_s)
  );

  tof_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(pll_lock_i),
    .level_o(lock_level_s), .rise_o(lock_rise_s), .fall_o(lock_fall_s)
  );

  assign unused_edges_s = ^{sclk_level_s, sclk_fall_s, load_fall_s, lock_rise_s};

  // SDIN needs no edge stage; same depth keeps it settled when the SCLK strobe arrives
  logic [SYNC_STAGES-1:0] sdin_sync_q, sdin_sync_d;
  logic                   sdin_s;

  // Advance the SDIN synchronizer chain
  always_comb begin
    sdin_sync_d = {sdin_sync_q[SYNC_STAGES-2:0], pll_sdin_i};
  end

  // SDIN synchronizer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sdin_sync_q <= '0;
    end else begin
      sdin_sync_q <= sdin_sync_d;
    end
  end

  assign sdin_s = sdin_sync_q[SYNC_STAGES-1];

  // Frame assembly state
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                frame_ok_s;
  c_bits_e             c_sel_s;

  assign frame_ok_s = (bitcnt_q == CNT_FULL);
  assign c_sel_s    = c_bits_e'(shift_q[1:0]);

  // Shift bits on SCLK rise, close the frame on LOAD rise (LOAD wins a tie)
  always_comb begin
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (load_rise_s) begin
      bitcnt_d = '0;
      if (frame_ok_s) begin
        word_d       = shift_q;
        word_valid_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (sclk_rise_s && !load_level_s) begin
      shift_d  = {shift_q[WORD_W-2:0], sdin_s};
      bitcnt_d = bitcnt_inc(bitcnt_q);
    end else begin
      shift_d = shift_q;
    end
  end

  // Frame assembly registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q      <= '0;
      bitcnt_q     <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Shadow registers and sticky status
  logic [WORD_W-1:0]   ctrl_q, ctrl_d;
  logic [WORD_W-1:0]   r_q, r_d;
  logic [WORD_W-1:0]   n_q, n_d;
  logic [2:0]          loaded_q, loaded_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic                lock_lost_q, lock_lost_d;

  // Route good words to their shadow, count bad frames, watch for lock loss once configured
  always_comb begin
    ctrl_d      = ctrl_q;
    r_d         = r_q;
    n_d         = n_q;
    loaded_d    = loaded_q;
    err_count_d = err_count_q;
    lock_lost_d = lock_lost_q;
    if (load_rise_s && frame_ok_s) begin
      case (c_sel_s)
        C_CTRL: begin
          ctrl_d      = shift_q;
          loaded_d[0] = 1'b1;
        end
        C_RCNT: begin
          r_d         = shift_q;
          loaded_d[1] = 1'b1;
        end
        C_NCNT: begin
          n_d         = shift_q;
          loaded_d[2] = 1'b1;
        end
        C_TEST: begin
          loaded_d = loaded_q;
        end
        default: begin
          loaded_d = loaded_q;
        end
      endcase
    end else if (load_rise_s && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
    if (lock_fall_s && (loaded_q == 3'b111)) begin
      lock_lost_d = 1'b1;
    end else begin
      lock_lost_d = lock_lost_q;
    end
  end

  // Shadow and status registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q      <= '0;
      r_q         <= '0;
      n_q         <= '0;
      loaded_q    <= 3'b000;
      err_count_q <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      r_q         <= r_d;
      n_q         <= n_d;
      loaded_q    <= loaded_d;
      err_count_q <= err_count_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign frame_err_o  = frame_err_q;
  assign ctrl_reg_o   = ctrl_q;
  assign r_reg_o      = r_q;
  assign n_reg_o      = n_q;
  assign loaded_o     = loaded_q;
  assign err_count_o  = err_count_q;
  assign lock_o       = lock_level_s;
  assign lock_lost_o  = lock_lost_q;

endmodule

// File: tb/tb_tof_pll_serial_monitor.sv
// Scoreboard bench for tof_pll_serial_monitor: a bit-level model predicts each
// word/frame-error event and the shadow state; events are compared as they appear.
module tb_tof_pll_serial_monitor;
  import tof_pll_serial_monitor_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pll_sclk_i = 1'b0;
  logic        pll_sdin_i = 1'b0;
  logic        pll_load_i = 1'b0;
  logic        pll_lock_i = 1'b0;
  logic [23:0] word_o;
  logic        word_valid_o;
  logic [23:0] ctrl_reg_o;
  logic [23:0] r_reg_o;
  logic [23:0] n_reg_o;
  logic [2:0]  loaded_o;
  logic        frame_err_o;
  logic [7:0]  err_count_o;
  logic        lock_o;
  logic        lock_lost_o;

  tof_pll_serial_monitor dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pll_sclk_i(pll_sclk_i), .pll_sdin_i(pll_sdin_i),
    .pll_load_i(pll_load_i), .pll_lock_i(pll_lock_i),
    .word_o(word_o), .word_valid_o(word_valid_o),
    .ctrl_reg_o(ctrl_reg_o), .r_reg_o(r_reg_o), .n_reg_o(n_reg_o),
    .loaded_o(loaded_o), .frame_err_o(frame_err_o), .err_count_o(err_count_o),
    .lock_o(lock_o), .lock_lost_o(lock_lost_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard of expected output events
  typedef struct {
    logic        is_err;
    logic [23:0] word;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  always @(negedge clk_i) begin
    if (!rst_i && (word_valid_o || frame_err_o)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_spurious", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check_eq("sb_valid", {31'd0, word_valid_o}, {31'd0, ~sb_e.is_err});
        check_eq("sb_ferr", {31'd0, frame_err_o}, {31'd0, sb_e.is_err});
        check_eq("sb_latency", cyc, sb_e.due);
        if (!sb_e.is_err) check_eq("sb_word", {8'd0, word_o}, {8'd0, sb_e.word});
      end
    end
  end

  // Bench model of the receiver
  logic [23:0] m_shift = 24'd0;
  int          m_cnt = 0;
  logic [23:0] m_word = 24'd0;
  logic [23:0] m_ctrl = 24'd0;
  logic [23:0] m_r = 24'd0;
  logic [23:0] m_n = 24'd0;
  logic [2:0]  m_loaded = 3'b000;
  int          m_err = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    pll_sdin_i = b;
    wait_cyc(4);
    pll_sclk_i = 1'b1;
    if (!pll_load_i) begin
      m_shift = {m_shift[22:0], b};
      if (m_cnt != 31) m_cnt++;
    end
    wait_cyc(4);
    pll_sclk_i = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
  endtask

  // Raise LOAD, predict the outcome, optionally toggle SCLK while LOAD is high
  task automatic do_load(input int extra_sclk);
    exp_t e;
    wait_cyc(4);
    pll_load_i = 1'b1;
    e.due = cyc + 4;
    if (m_cnt == 24) begin
      e.is_err = 1'b0;
      e.word   = m_shift;
      m_word   = m_shift;
      case (m_shift[1:0])
        2'b00: begin m_ctrl = m_shift; m_loaded[0] = 1'b1; end
        2'b01: begin m_r = m_shift; m_loaded[1] = 1'b1; end
        2'b10: begin m_n = m_shift; m_loaded[2] = 1'b1; end
        default: ;
      endcase
    end else begin
      e.is_err = 1'b1;
      e.word   = 24'd0;
      if (m_err != 255) m_err++;
    end
    sb_q.push_back(e);
    m_cnt = 0;
    wait_cyc(6);
    for (int k = 0; k < extra_sclk; k++) send_bit(1'($urandom_range(0, 1)));
    pll_load_i = 1'b0;
    wait_cyc(6);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits({8'd0, w}, 24);
    do_load(0);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_word"}, {8'd0, word_o}, {8'd0, m_word});
    check_eq({tag, "_ctrl"}, {8'd0, ctrl_reg_o}, {8'd0, m_ctrl});
    check_eq({tag, "_r"}, {8'd0, r_reg_o}, {8'd0, m_r});
    check_eq({tag, "_n"}, {8'd0, n_reg_o}, {8'd0, m_n});
    check_eq({tag, "_loaded"}, {29'd0, loaded_o}, {29'd0, m_loaded});
    check_eq({tag, "_errcnt"}, {24'd0, err_count_o}, m_err);
  endtask

  task automatic model_reset();
    m_shift = 24'd0; m_cnt = 0; m_word = 24'd0;
    m_ctrl = 24'd0; m_r = 24'd0; m_n = 24'd0;
    m_loaded = 3'b000; m_err = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(3);
    check_state("reset");
    check_eq("reset_valid", {31'd0, word_valid_o}, 32'd0);
    check_eq("reset_ferr", {31'd0, frame_err_o}, 32'd0);
    check_eq("reset_lock", {31'd0, lock_o}, 32'd0);
    check_eq("reset_locklost", {31'd0, lock_lost_o}, 32'd0);
    rst_i = 1'b0;
    pll_lock_i = 1'b1;
    wait_cyc(6);
    check_eq("lock_sync", {31'd0, lock_o}, 32'd1);

    // 1: power-up programming sequence
    send_word(INIT_R_WORD);
    send_word(INIT_CTRL_WORD);
    send_word(INIT_N_WORD);
    check_state("t1");
    check_eq("t1_r_const", {8'd0, r_reg_o}, 32'h0034002D);
    check_eq("t1_loaded_const", {29'd0, loaded_o}, 32'd7);

    // 2: short and long frames
    send_bits(32'h0012345, 23);
    do_load(0);
    send_bits(32'h1ABCDEF, 25);
    do_load(0);
    check_state("t2");
    check_eq("t2_errcnt_const", {24'd0, err_count_o}, 32'd2);

    // 3: test-mode word, no shadow write
    send_word(24'hFFFFFF);
    check_state("t3");

    // 4: SCLK activity while LOAD held high is ignored
    send_bits(32'h00123456, 24);
    do_load(3);
    send_word(24'h00ABC9);
    check_state("t4");

    // 5: reset mid-frame, then a full control word
    send_bits(32'h00000FFF, 12);
    rst_i = 1'b1;
    wait_cyc(3);
    model_reset();
    sb_q.delete();
    rst_i = 1'b0;
    wait_cyc(6);
    send_word(INIT_CTRL_WORD);
    check_state("t5");

    // lock drop before all three registers are loaded does not set lock_lost
    pll_lock_i = 1'b0;
    wait_cyc(6);
    check_eq("t5_lock_low", {31'd0, lock_o}, 32'd0);
    check_eq("t5_locklost", {31'd0, lock_lost_o}, 32'd0);
    pll_lock_i = 1'b1;
    wait_cyc(6);

    // 6: saturate error counter, then lose lock with everything loaded
    send_word(INIT_R_WORD);
    send_word(INIT_N_WORD);
    for (int i = 0; i < 300; i++) do_load(0);
    check_state("t6");
    check_eq("t6_errsat", {24'd0, err_count_o}, 32'd255);
    pll_lock_i = 1'b0;
    wait_cyc(6);
    check_eq("t6_lock_low", {31'd0, lock_o}, 32'd0);
    check_eq("t6_locklost", {31'd0, lock_lost_o}, 32'd1);
    pll_lock_i = 1'b1;
    wait_cyc(6);
    check_eq("t6_lock_back", {31'd0, lock_o}, 32'd1);
    check_eq("t6_locklost_sticky", {31'd0, lock_lost_o}, 32'd1);

    wait_cyc(10);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
